icache_fetch: RTL and testbench

// - Direct-mapped instruction cache between the IF stage and mem_ctrl's IF port.
// - Hits return an instruction with 1-cycle latency.
// - Misses drive if_request/if_addr to mem_ctrl, wait for if_enable, fill the line, then deliver.
// - Honours pipeline flush (failed) and whole-cache invalidate (fence.i).

---
 rtl/icache_fetch_if.sv | 28 ++
 rtl/icache_fetch.sv | 129 ++++++++++++
 tb/tb_icache_fetch.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_if.sv
// Fetch-side and mem_ctrl-side signals of the instruction cache, bundled.
// slave = cache, master = IF stage / mem_ctrl / testbench.
interface icache_fetch_if #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned INST_LEN = 32
);
  logic                rdy;
  logic [ADDR_LEN-1:0] pc_addr;
  logic                pc_req;
  logic                failed;
  logic                invalidate;
  logic [INST_LEN-1:0] inst_out;
  logic                inst_valid;
  logic [ADDR_LEN-1:0] mem_if_addr;
  logic                mem_if_request;
  logic [INST_LEN-1:0] mem_if_inst;
  logic                mem_if_enable;

  modport master (
    output rdy, pc_addr, pc_req, failed, invalidate, mem_if_inst, mem_if_enable,
    input  inst_out, inst_valid, mem_if_addr, mem_if_request
  );

  modport slave (
    input  rdy, pc_addr, pc_req, failed, invalidate, mem_if_inst, mem_if_enable,
    output inst_out, inst_valid, mem_if_addr, mem_if_request
  );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache between IF and mem_ctrl.
// Define ICACHE_STATS_EN to add hit_cnt/miss_cnt lookup counters.
module icache_fetch #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_LEN   = 32,
  parameter int unsigned INST_LEN   = 32
) (
  input  logic          clk,
  input  logic          rst,
  icache_fetch_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);
  localparam int unsigned LINES    = 2 ** INDEX_BITS;
  localparam int unsigned TAG_BITS = ADDR_LEN - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                state, state_next;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [INST_LEN-1:0]   data_mem [LINES];

  logic [INDEX_BITS-1:0] pc_index, fill_index;
  logic [TAG_BITS-1:0]   pc_tag, fill_tag;
  logic                  hit;
  logic                  lookup;
  logic                  fill_we;
  logic [INST_LEN-1:0]   inst_out_next;
  logic                  inst_valid_next;
  logic                  request_next;
  logic [ADDR_LEN-1:0]   addr_next;

  assign pc_index   = bus.pc_addr[INDEX_BITS+1:2];
  assign pc_tag     = bus.pc_addr[ADDR_LEN-1:INDEX_BITS+2];
  // The latched miss address supplies the refill line, so pc_addr is free during MISS.
  assign fill_index = bus.mem_if_addr[INDEX_BITS+1:2];
  assign fill_tag   = bus.mem_if_addr[ADDR_LEN-1:INDEX_BITS+2];
  assign hit        = valid[pc_index] && (tag_mem[pc_index] == pc_tag);

  always_comb begin
    state_next      = state;
    inst_out_next   = bus.inst_out;
    inst_valid_next = 1'b0;
    request_next    = bus.mem_if_request;
    addr_next       = bus.mem_if_addr;
    fill_we         = 1'b0;
    lookup          = 1'b0;
    if (bus.failed) begin
      state_next   = IDLE;
      request_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pc_req) begin
            lookup = 1'b1;
            if (hit) begin
              inst_out_next   = data_mem[pc_index];
              inst_valid_next = 1'b1;
            end else begin
              addr_next    = {bus.pc_addr[ADDR_LEN-1:2], 2'b00};
              request_next = 1'b1;
              state_next   = MISS;
            end
          end
        end
        MISS: begin
          if (bus.mem_if_enable) begin
            // A coincident invalidate suppresses the write but not the delivery.
            fill_we         = !bus.invalidate;
            inst_out_next   = bus.mem_if_inst;
            inst_valid_next = 1'b1;
            request_next    = 1'b0;
            state_next      = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      valid              <= '0;
      bus.inst_out       <= '0;
      bus.inst_valid     <= 1'b0;
      bus.mem_if_addr    <= '0;
      bus.mem_if_request <= 1'b0;
    end else if (bus.rdy) begin
      state              <= state_next;
      bus.inst_out       <= inst_out_next;
      bus.inst_valid     <= inst_valid_next;
      bus.mem_if_addr    <= addr_next;
      bus.mem_if_request <= request_next;
      if (bus.invalidate) begin
        valid <= '0;
      end else if (fill_we) begin
        valid[fill_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.rdy && fill_we) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= bus.mem_if_inst;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (bus.rdy && lookup) begin
      if (hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Randomized scoreboard bench for icache_fetch against an address-level cache model.
module tb_icache_fetch;
  logic clk;
  logic rst;

  icache_fetch_if #(.ADDR_LEN(32), .INST_LEN(32)) bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_fetch #(.INDEX_BITS(6), .ADDR_LEN(32), .INST_LEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];

  // Reference model: 64 lines, 256-byte alias span, one word per line.
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] n_hit;
  logic [31:0] n_miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0004) return 32'h0051_0513;
    return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // Monitor: every delivered instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_inst_valid: got inst_out %h with no pending fetch (t=%0t)",
                 bus.inst_out, $time);
      end else begin
        chk("inst_out", bus.inst_out, exp_q.pop_front());
      end
    end
  end

  // mode: 0 normal, 1 flush on refill, 2 invalidate on refill, 3 reset mid-miss,
  //       4 flush coincident with the lookup. lat=0 picks a random latency.
  task automatic do_fetch(input logic [31:0] a, input int mode, input int lat, input bit stall);
    int          idx;
    logic [31:0] tg;
    logic [31:0] w;
    bit          hit;
    int          n;
    idx = int'((a >> 2) % 64);
    tg  = a >> 8;
    w   = mem_word(a);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    @(negedge clk);
    bus.pc_addr = a;
    bus.pc_req  = 1'b1;
    if (mode == 4) begin
      bus.failed = 1'b1;
      @(negedge clk);
      bus.pc_req = 1'b0;
      bus.failed = 1'b0;
      chk("flush_lookup_no_req", {31'd0, bus.mem_if_request}, 32'd0);
      return;
    end
    if (hit) begin
      exp_q.push_back(m_data[idx]);
      n_hit++;
    end
    @(negedge clk);
    bus.pc_req = 1'b0;
    if (hit) begin
      chk("hit_no_req", {31'd0, bus.mem_if_request}, 32'd0);
      return;
    end
    n_miss++;
    chk("miss_req", {31'd0, bus.mem_if_request}, 32'd1);
    chk("miss_addr", bus.mem_if_addr, {a[31:2], 2'b00});
    n = (lat == 0) ? int'($urandom_range(4, 8)) : lat;
    for (int i = 0; i < n; i++) begin
      if (stall && i == 1) begin
        bus.rdy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_req", {31'd0, bus.mem_if_request}, 32'd1);
          chk("stall_addr", bus.mem_if_addr, {a[31:2], 2'b00});
        end
        bus.rdy = 1'b1;
      end
      @(negedge clk);
    end
    if (mode == 3) begin
      rst = 1'b1;
      @(negedge clk);
      chk("rst_drops_req", {31'd0, bus.mem_if_request}, 32'd0);
      rst = 1'b0;
      model_clear();
      n_hit  = '0;
      n_miss = '0;
      return;
    end
    bus.mem_if_inst   = w;
    bus.mem_if_enable = 1'b1;
    if (mode == 1) bus.failed = 1'b1;
    if (mode == 2) bus.invalidate = 1'b1;
    if (mode != 1) exp_q.push_back(w);
    @(negedge clk);
    bus.mem_if_enable = 1'b0;
    bus.failed        = 1'b0;
    bus.invalidate    = 1'b0;
    bus.mem_if_inst   = $urandom;
    if (mode == 0) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = w;
    end else if (mode == 2) begin
      model_clear();
    end
    chk("req_dropped", {31'd0, bus.mem_if_request}, 32'd0);
  endtask

  task automatic inv_pulse();
    @(negedge clk);
    bus.invalidate = 1'b1;
    @(negedge clk);
    bus.invalidate = 1'b0;
    model_clear();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
    if ($urandom_range(0, 7) == 0) a = a | 32'h1000_0000;
    return a;
  endfunction

  initial begin
    int r;
    rst               = 1'b1;
    bus.rdy           = 1'b1;
    bus.pc_addr       = '0;
    bus.pc_req        = 1'b0;
    bus.failed        = 1'b0;
    bus.invalidate    = 1'b0;
    bus.mem_if_inst   = '0;
    bus.mem_if_enable = 1'b0;
    model_clear();
    n_hit  = '0;
    n_miss = '0;
    repeat (3) @(negedge clk);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst_out", bus.inst_out, 32'd0);
    chk("rst_req", {31'd0, bus.mem_if_request}, 32'd0);
    chk("rst_addr", bus.mem_if_addr, 32'd0);
    rst = 1'b0;

    do_fetch(32'h0000_0004, 0, 4, 1'b0);  // cold miss
    do_fetch(32'h0000_0004, 0, 0, 1'b0);  // hit after fill
    do_fetch(32'h0000_0104, 0, 0, 1'b0);  // alias replaces line
    do_fetch(32'h0000_0004, 0, 0, 1'b0);  // original now misses
    do_fetch(32'h0000_0008, 1, 0, 1'b0);  // flush on refill
    do_fetch(32'h0000_0008, 0, 0, 1'b0);  // must miss again
    do_fetch(32'h0000_0000, 0, 0, 1'b0);
    do_fetch(32'h0000_0004, 0, 0, 1'b0);
    inv_pulse();
    do_fetch(32'h0000_0004, 0, 0, 1'b0);  // miss after invalidate
    do_fetch(32'h0000_0010, 0, 5, 1'b1);  // rdy stall during MISS
    do_fetch(32'h0000_0010, 0, 0, 1'b0);
    do_fetch(32'h0000_0020, 2, 0, 1'b0);  // invalidate on refill: delivered, not kept
    do_fetch(32'h0000_0020, 0, 0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 39));
      if (r < 2)       do_fetch(rand_addr(), 1, 0, 1'b0);
      else if (r < 4)  do_fetch(rand_addr(), 2, 0, 1'b0);
      else if (r < 6)  do_fetch(rand_addr(), 4, 0, 1'b0);
      else if (r < 7)  inv_pulse();
      else if (r < 10) do_fetch(rand_addr(), 0, 0, 1'b1);
      else             do_fetch(rand_addr(), 0, 0, 1'b0);
    end

`ifdef ICACHE_STATS_EN
    @(negedge clk);
    chk("hit_cnt", hit_cnt, n_hit);
    chk("miss_cnt", miss_cnt, n_miss);
`endif
    do_fetch(32'h0000_0030, 3, 0, 1'b0);  // reset mid-miss
    do_fetch(32'h0000_0004, 0, 0, 1'b0);  // line gone after reset
`ifdef ICACHE_STATS_EN
    @(negedge clk);
    chk("hit_cnt_after_rst", hit_cnt, n_hit);
    chk("miss_cnt_after_rst", miss_cnt, n_miss);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
